// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared battleship board constants, selector states and cell helpers
package battleship_pkg;

  localparam int         BOARD_N = 5;
  localparam logic [4:0] NO_SEL  = 5'd5;
  localparam logic [2:0] LAST_RC = 3'(BOARD_N - 1);

  typedef enum logic [2:0] {IDLE, AIM, COMMIT, SCAN, DONE} sel_state_t;

  function automatic logic [4:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return 5'(row) * 5'(BOARD_N) + 5'(col);
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == LAST_RC) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] wrap_dec(input logic [2:0] v);
    return (v == 3'd0) ? LAST_RC : v - 3'd1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn seconds countdown driven by a clock-cycle prescaler
module turn_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TURN_SECONDS  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  output logic       tick,
  output logic [3:0] time_left,
  output logic       expired
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PW-1:0] presc;

  assign tick    = enable && (presc == PW'(TICKS_PER_SEC - 1));
  assign expired = (time_left == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      time_left <= '0;
    end else if (load) begin
      presc     <= '0;
      time_left <= 4'(TURN_SECONDS);
    end else if (enable) begin
      if (tick) begin
        presc <= '0;
        if (time_left != 4'd0) time_left <= time_left - 4'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shot_selector.sv
// rtl/shot_selector.sv - player shot selection: cursor aiming, turn timer and auto-fire scan
module shot_selector
  import battleship_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TURN_SECONDS  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic        turn_en,
  output logic [4:0]  selected_row,
  output logic [4:0]  selected_col,
  output logic [2:0]  cursor_row,
  output logic [2:0]  cursor_col,
  output logic [24:0] shot_mask,
  output logic [3:0]  time_left,
  output logic        timeout,
  output logic        reject,
  output logic        board_full
);

  sel_state_t state;
  logic [2:0] scan_row, scan_col;
  logic [4:0] scan_cnt;
  logic       timer_en, timer_load, tick, expired, final_sec;
  logic       cursor_shot, scan_shot;

  assign timer_en    = (state == AIM);
  assign timer_load  = (state == IDLE) && turn_en;
  assign cursor_shot = shot_mask[cell_idx(cursor_row, cursor_col)];
  assign scan_shot   = shot_mask[cell_idx(scan_row, scan_col)];
  // Last tick of the turn, or a turn that was loaded with no time at all.
  assign final_sec   = (tick && time_left == 4'd1) || expired;

  turn_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .TURN_SECONDS (TURN_SECONDS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (timer_en),
    .load     (timer_load),
    .tick     (tick),
    .time_left(time_left),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cursor_row   <= '0;
      cursor_col   <= '0;
      shot_mask    <= '0;
      selected_row <= NO_SEL;
      selected_col <= NO_SEL;
      scan_row     <= '0;
      scan_col     <= '0;
      scan_cnt     <= '0;
      timeout      <= 1'b0;
      reject       <= 1'b0;
      board_full   <= 1'b0;
    end else begin
      timeout      <= 1'b0;
      reject       <= 1'b0;
      board_full   <= 1'b0;
      selected_row <= NO_SEL;
      selected_col <= NO_SEL;
      case (state)
        IDLE: if (turn_en) state <= AIM;
        AIM: begin
          if (!turn_en) begin
            state <= IDLE;
          end else if (&shot_mask) begin
            board_full <= 1'b1;
            state      <= DONE;
          end else if (btn_fire && !cursor_shot) begin
            selected_row <= 5'(cursor_row);
            selected_col <= 5'(cursor_col);
            state        <= COMMIT;
          end else begin
            if (btn_fire)       reject     <= 1'b1;
            else if (btn_up)    cursor_row <= wrap_dec(cursor_row);
            else if (btn_down)  cursor_row <= wrap_inc(cursor_row);
            else if (btn_left)  cursor_col <= wrap_dec(cursor_col);
            else if (btn_right) cursor_col <= wrap_inc(cursor_col);
            // The scan starts from where the cursor stood when time ran out.
            if (final_sec) begin
              timeout  <= 1'b1;
              scan_row <= cursor_row;
              scan_col <= cursor_col;
              scan_cnt <= '0;
              state    <= SCAN;
            end
          end
        end
        COMMIT: begin
          shot_mask[cell_idx(cursor_row, cursor_col)] <= 1'b1;
          state <= DONE;
        end
        SCAN: begin
          if (!turn_en) begin
            state <= IDLE;
          end else if (!scan_shot) begin
            cursor_row   <= scan_row;
            cursor_col   <= scan_col;
            selected_row <= 5'(scan_row);
            selected_col <= 5'(scan_col);
            state        <= COMMIT;
          end else if (scan_cnt == 5'(BOARD_N * BOARD_N - 1)) begin
            board_full <= 1'b1;
            state      <= DONE;
          end else begin
            scan_cnt <= scan_cnt + 5'd1;
            scan_col <= wrap_inc(scan_col);
            if (scan_col == LAST_RC) scan_row <= wrap_inc(scan_row);
          end
        end
        DONE: if (!turn_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shot_selector.md
SHOT_SELECTOR -- requirements
Module: shot_selector

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clock cycles per one-second timer tick.
REQ-002 SHALL have parameter TURN_SECONDS, default 15, meaning the turn time limit in seconds (4-bit range).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_fire  input  1 each  meaning single-cycle, already-debounced button pulses.
REQ-006 SHALL have port turn_en  input  1  meaning it is the player's turn.
REQ-007 SHALL have ports selected_row, selected_col  output  5 each  meaning the committed target; value 5 means no selection.
REQ-008 SHALL have ports cursor_row, cursor_col  output  3 each  meaning the current cursor position, range 0..4.
REQ-009 SHALL have port shot_mask  output  25  meaning cells already fired on; bit index is row*5+col.
REQ-010 SHALL have port time_left  output  4  meaning the whole seconds remaining in the turn.
REQ-011 SHALL have ports timeout, reject, board_full  output  1 each  meaning single-cycle event pulses.

Function
REQ-012 SHALL implement states IDLE, AIM, COMMIT, SCAN and DONE.
REQ-013 IDLE SHALL go to AIM when turn_en=1, loading time_left=TURN_SECONDS and clearing the prescaler.
REQ-014 In AIM, SHALL act on at most one button per cycle, with priority fire > up > down > left > right.
REQ-015 Cursor moves SHALL wrap around: up from row 0 goes to row 4, down from row 4 goes to row 0, and columns wrap the same way.
REQ-016 In AIM, fire on a cell whose shot_mask bit is 0 SHALL go to COMMIT.
REQ-017 In AIM, fire on a cell whose shot_mask bit is 1 SHALL pulse reject for 1 cycle, stay in AIM, and leave the timer running.
REQ-018 COMMIT SHALL drive selected_row/col = cursor for exactly 1 cycle, set the shot_mask bit, then go to DONE; outside COMMIT, selected_row/col SHALL be 5.
REQ-019 The prescaler SHALL count only in AIM and SHALL emit one tick every TICKS_PER_SEC cycles; each tick SHALL decrement time_left.
REQ-020 When time_left reaches 0, SHALL pulse timeout for 1 cycle and go to SCAN in the same cycle.
REQ-021 SCAN SHALL start at the cursor index, test one cell per cycle, and advance index mod 25 (24 wraps to 0).
REQ-022 SCAN SHALL move the cursor to the first unshot cell and then go to COMMIT.
REQ-023 If all 25 cells are shot, SCAN SHALL pulse board_full after at most 25 cycles and go to DONE with no selection.
REQ-024 On entering AIM, if shot_mask is all ones, SHALL pulse board_full and go to DONE.
REQ-025 DONE SHALL hold until turn_en=0, then go to IDLE.
REQ-026 If turn_en falls in AIM or SCAN, SHALL go to IDLE with no selection, no mask change and no timeout pulse.
REQ-027 If fire and the final tick occur in the same cycle, fire SHALL win: go to COMMIT with no timeout pulse.
REQ-028 The cursor SHALL persist across turns.
REQ-029 Buttons SHALL be ignored outside AIM.

Reset
REQ-030 Asserting rst=0 SHALL immediately force: state IDLE, cursor 0/0, shot_mask 0, time_left 0, prescaler 0, selected_row/col 5, and timeout/reject/board_full 0.
REQ-031 Reset asserted in any state, including mid-SCAN or COMMIT, SHALL abandon the operation with no selection emitted.
REQ-032 Leaving reset SHALL take effect on the first clk edge after rst=1.

Structure
REQ-033 The state enum, BOARD_N=5, NO_SEL=5 and the bit-index function row*5+col SHALL live in a shared battleship package, also used by the player and PC blocks.
REQ-034 The prescaler and seconds counter SHALL be one sub-module, turn_timer (enable, load, tick, time_left, expired); everything else SHALL be flat.

Verification (TICKS_PER_SEC=4, TURN_SECONDS=15)
REQ-035 Reset, turn_en=1, right x2, down x1, fire -> selected=(1,2) for exactly 1 cycle, shot_mask bit 7 set, then DONE.
REQ-036 Cursor (0,0): up, then left -> cursor (4,4); from (4,4): down, then right -> cursor (0,0).
REQ-037 Fire on an already-shot (1,2) -> reject pulse, no selection, time_left unchanged.
REQ-038 No buttons for 60 cycles with cells 0..3 shot and cursor (0,0) -> timeout at cycle 60, SCAN, selected=(0,4).
REQ-039 All 25 bits shot, turn_en=1 -> board_full pulse, selected stays 5.
REQ-040 turn_en falls mid-AIM -> IDLE, no selection; rst=0 mid-SCAN -> all outputs at reset values immediately.
